// File: rtl/closest_hit_if.sv
// Bundles the hit/t input FIFO heads, their pops, and the single-entry result port of closest_hit.
interface closest_hit_if #(
  parameter int unsigned IDX_WIDTH = 16
);
  logic                  hit_in_dout;
  logic                  hit_in_empty;
  logic                  hit_in_rd_en;
  logic signed [31:0]    t_in_dout;
  logic                  t_in_empty;
  logic                  t_in_rd_en;
  logic                  out_hit;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic signed [31:0]    out_t;
  logic                  out_empty;
  logic                  out_rd_en;

  modport slave (
    input  hit_in_dout, hit_in_empty, t_in_dout, t_in_empty, out_rd_en,
    output hit_in_rd_en, t_in_rd_en, out_hit, out_idx, out_t, out_empty
  );

  modport master (
    output hit_in_dout, hit_in_empty, t_in_dout, t_in_empty, out_rd_en,
    input  hit_in_rd_en, t_in_rd_en, out_hit, out_idx, out_t, out_empty
  );
endinterface

// File: rtl/closest_hit.sv
// Nearest-hit reduction over TRI_COUNT triangles per ray, one result held until popped.
// Optional CLOSEST_HIT_TCLIP_EN: only hits with t > 0 are accepted.
module closest_hit #(
  parameter int unsigned Q_BITS    = 10,
  parameter int unsigned TRI_COUNT = 16,
  parameter int unsigned IDX_WIDTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  closest_hit_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(TRI_COUNT + 1);
  localparam logic signed [31:0] T_MAX = 32'sh7FFF_FFFF;

  if (TRI_COUNT < 1 || TRI_COUNT > 65535) begin : g_bad_count
    $error("closest_hit: TRI_COUNT out of range");
  end
  if (Q_BITS > 31) begin : g_bad_q
    $error("closest_hit: Q_BITS must leave an integer bit in t");
  end
  if ((TRI_COUNT - 1) >= (64'd1 << IDX_WIDTH)) begin : g_bad_idx
    $error("closest_hit: IDX_WIDTH too narrow for TRI_COUNT");
  end

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  found_q, found_d;
  logic signed [31:0]    best_t_q, best_t_d;
  logic [IDX_WIDTH-1:0]  best_idx_q, best_idx_d;
  logic                  out_hit_q, out_hit_d;
  logic [IDX_WIDTH-1:0]  out_idx_q, out_idx_d;
  logic signed [31:0]    out_t_q, out_t_d;

  logic                  consume;
  logic                  accept;
  logic                  replace;
  logic                  last;
  logic                  rd_en;
  logic                  nxt_found;
  logic signed [31:0]    nxt_t;
  logic [IDX_WIDTH-1:0]  nxt_idx;

  always_comb begin
    consume = (state_q == ACCUM) && !bus.hit_in_empty && !bus.t_in_empty;
`ifdef CLOSEST_HIT_TCLIP_EN
    accept  = consume && bus.hit_in_dout && (bus.t_in_dout > 32'sd0);
`else
    accept  = consume && bus.hit_in_dout;
`endif
    // Strict less-than keeps the earlier (lower) index on a tie.
    replace = accept && (!found_q || (bus.t_in_dout < best_t_q));
    last    = (cnt_q == CNT_W'(TRI_COUNT - 1));

    nxt_found = found_q | replace;
    nxt_t     = replace ? bus.t_in_dout       : best_t_q;
    nxt_idx   = replace ? IDX_WIDTH'(cnt_q)   : best_idx_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    found_d    = found_q;
    best_t_d   = best_t_q;
    best_idx_d = best_idx_q;
    out_hit_d  = out_hit_q;
    out_idx_d  = out_idx_q;
    out_t_d    = out_t_q;
    rd_en      = 1'b0;

    case (state_q)
      ACCUM: begin
        if (consume) begin
          rd_en = 1'b1;
          if (last) begin
            out_hit_d  = nxt_found;
            out_idx_d  = nxt_idx;
            out_t_d    = nxt_t;
            cnt_d      = '0;
            found_d    = 1'b0;
            best_t_d   = T_MAX;
            best_idx_d = '0;
            state_d    = EMIT;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            found_d    = nxt_found;
            best_t_d   = nxt_t;
            best_idx_d = nxt_idx;
          end
        end
      end
      EMIT: begin
        if (bus.out_rd_en) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ACCUM;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      best_t_q   <= T_MAX;
      best_idx_q <= '0;
      out_hit_q  <= 1'b0;
      out_idx_q  <= '0;
      out_t_q    <= T_MAX;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      best_t_q   <= best_t_d;
      best_idx_q <= best_idx_d;
      out_hit_q  <= out_hit_d;
      out_idx_q  <= out_idx_d;
      out_t_q    <= out_t_d;
    end
  end

  // Pops are gated by reset so nothing is consumed while reset is held.
  assign bus.hit_in_rd_en = rd_en && !reset;
  assign bus.t_in_rd_en   = rd_en && !reset;
  assign bus.out_hit      = out_hit_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_t        = out_t_q;
  assign bus.out_empty    = (state_q != EMIT);

endmodule

// File: tb/tb_closest_hit.sv
// Directed self-checking bench for closest_hit with TRI_COUNT=4.
module tb_closest_hit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  closest_hit_if #(.IDX_WIDTH(16)) bus ();

  closest_hit #(
    .Q_BITS    (10),
    .TRI_COUNT (4),
    .IDX_WIDTH (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input logic h, input logic [15:0] idx,
                            input logic [31:0] t);
    chk({tag, "_empty"}, 32'(bus.out_empty), 32'd0);
    chk({tag, "_hit"},   32'(bus.out_hit),   32'(h));
    chk({tag, "_idx"},   32'(bus.out_idx),   32'(idx));
    chk({tag, "_t"},     bus.out_t,          t);
  endtask

  // Presents one pair for exactly one cycle; caller is at posedge+1.
  task automatic feed(input logic h, input logic [31:0] t);
    bus.hit_in_dout  = h;
    bus.t_in_dout    = t;
    bus.hit_in_empty = 1'b0;
    bus.t_in_empty   = 1'b0;
    #1;
    chk("pop_hit", 32'(bus.hit_in_rd_en), 32'd1);
    chk("pop_t",   32'(bus.t_in_rd_en),   32'd1);
    chk("pre_empty", 32'(bus.out_empty),  32'd1);
    @(posedge clock); #1;
    bus.hit_in_empty = 1'b1;
    bus.t_in_empty   = 1'b1;
  endtask

  task automatic pop_result();
    bus.out_rd_en = 1'b1;
    @(posedge clock); #1;
    bus.out_rd_en = 1'b0;
    chk("popped_empty", 32'(bus.out_empty), 32'd1);
  endtask

  initial begin
    bus.hit_in_dout  = 1'b0;
    bus.t_in_dout    = '0;
    bus.hit_in_empty = 1'b1;
    bus.t_in_empty   = 1'b1;
    bus.out_rd_en    = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    bus.hit_in_empty = 1'b0;
    bus.t_in_empty   = 1'b0;
    #1;
    chk("rst_rd_hit", 32'(bus.hit_in_rd_en), 32'd0);
    chk("rst_rd_t",   32'(bus.t_in_rd_en),   32'd0);
    chk("rst_empty",  32'(bus.out_empty),    32'd1);
    chk("rst_hit",    32'(bus.out_hit),      32'd0);
    chk("rst_idx",    32'(bus.out_idx),      32'd0);
    chk("rst_t",      bus.out_t,             32'h7FFF_FFFF);
    bus.hit_in_empty = 1'b1;
    bus.t_in_empty   = 1'b1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Pop request with nothing held must be ignored
    bus.out_rd_en = 1'b1;
    @(posedge clock); #1;
    bus.out_rd_en = 1'b0;
    chk("idle_pop_empty", 32'(bus.out_empty), 32'd1);

    feed(1'b0, 32'd5); feed(1'b1, 32'd300); feed(1'b1, 32'd200); feed(1'b0, 32'd100);
    chk_result("grpA", 1'b1, 16'd2, 32'd200);
    pop_result();

    feed(1'b0, 32'd1); feed(1'b0, 32'd2); feed(1'b0, 32'd3); feed(1'b0, 32'd4);
    chk_result("nohit", 1'b0, 16'd0, 32'h7FFF_FFFF);
    pop_result();

    feed(1'b1, 32'd64); feed(1'b1, 32'd64); feed(1'b0, 32'd1); feed(1'b0, 32'd2);
    chk_result("tie", 1'b1, 16'd0, 32'd64);
    pop_result();

    feed(1'b1, -32'sd50); feed(1'b1, 32'd0); feed(1'b1, 32'd80); feed(1'b1, 32'd40);
`ifdef CLOSEST_HIT_TCLIP_EN
    chk_result("sign", 1'b1, 16'd3, 32'd40);
`else
    chk_result("sign", 1'b1, 16'd0, -32'sd50);
`endif

    // Backpressure: inputs available, result held, nothing may pop
    bus.hit_in_dout  = 1'b1;
    bus.t_in_dout    = 32'd1;
    bus.hit_in_empty = 1'b0;
    bus.t_in_empty   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("bp_rd_hit", 32'(bus.hit_in_rd_en), 32'd0);
      chk("bp_rd_t",   32'(bus.t_in_rd_en),   32'd0);
`ifdef CLOSEST_HIT_TCLIP_EN
      chk("bp_idx", 32'(bus.out_idx), 32'd3);
      chk("bp_t",   bus.out_t,        32'd40);
`else
      chk("bp_idx", 32'(bus.out_idx), 32'd0);
      chk("bp_t",   bus.out_t,        -32'sd50);
`endif
    end
    bus.hit_in_empty = 1'b1;
    bus.t_in_empty   = 1'b1;
    pop_result();

    // Independent empty flags: no pop unless both heads are present
    bus.hit_in_dout  = 1'b1;
    bus.t_in_dout    = 32'd30;
    bus.hit_in_empty = 1'b0;
    bus.t_in_empty   = 1'b1;
    #1;
    chk("stall_a_hit", 32'(bus.hit_in_rd_en), 32'd0);
    chk("stall_a_t",   32'(bus.t_in_rd_en),   32'd0);
    @(posedge clock); #1;
    bus.hit_in_empty = 1'b1;
    bus.t_in_empty   = 1'b0;
    #1;
    chk("stall_b_hit", 32'(bus.hit_in_rd_en), 32'd0);
    chk("stall_b_t",   32'(bus.t_in_rd_en),   32'd0);
    @(posedge clock); #1;
    feed(1'b1, 32'd30);
    bus.hit_in_empty = 1'b0;
    #1;
    chk("stall_c_t", 32'(bus.t_in_rd_en), 32'd0);
    @(posedge clock); #1;
    bus.hit_in_empty = 1'b1;
    feed(1'b1, 32'd10); feed(1'b1, 32'd20); feed(1'b0, 32'd0);
    chk_result("stall", 1'b1, 16'd1, 32'd10);
    pop_result();

    // Reset mid-group discards the partial group
    feed(1'b1, 32'd7); feed(1'b1, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_empty", 32'(bus.out_empty), 32'd1);
    chk("mid_rst_hit",   32'(bus.out_hit),   32'd0);
    chk("mid_rst_idx",   32'(bus.out_idx),   32'd0);
    chk("mid_rst_t",     bus.out_t,          32'h7FFF_FFFF);
    @(posedge clock); #1;
    reset = 1'b0;
    feed(1'b0, 32'd1); feed(1'b0, 32'd2); feed(1'b1, 32'd9); feed(1'b1, 32'd8);
    chk_result("post_rst", 1'b1, 16'd3, 32'd8);
    pop_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
